multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3, ALU control width; legal values are 3 or more, and upper bits are zero-filled.
REQ-002 SHALL have parameter STATE_W, default 4, width of the debug state port; legal values are 4 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port opcode, input, 6 bits: instruction register [31:26].
REQ-006 SHALL have port funct, input, 6 bits: instruction register [5:0].
REQ-007 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have ports pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg and regdst, each an output of 1 bit: datapath enables and selects.
REQ-009 SHALL have ports alusrcb and pcsrc, each an output of 2 bits: mux selects.
REQ-010 SHALL have port alucontrol, output, ALUCTRL_W bits: ALU operation.
REQ-011 SHALL have port state_dbg, output, STATE_W bits: current FSM state encoding, zero-extended.

Function
REQ-012 SHALL implement a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-013 SHALL use the following transitions:
- FETCH->DECODE.
- DECODE on opcode: lw 100011 / sw 101011 -> MEMADR; R 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEXEC; j 000010 -> JUMP.
REQ-014 SHALL use the following transitions:
- MEMADR -> MEMRD for lw, MEMWR for sw.
- MEMRD->MEMWB.
- EXECUTE->ALUWB.
- ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
REQ-015 SHALL, in DECODE, return to FETCH for any unlisted opcode (treated as a no-op); no write strobe is asserted.
REQ-016 SHALL force any unused state encoding (12-15) to FETCH on the next edge, with all outputs at their defaults.
REQ-017 SHALL drive these non-default outputs per state:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR and ADDIEXEC: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regwrite=1.
- JUMP: pcsrc=10, pcwrite=1.
- All other outputs and internal signals default to 0.
REQ-018 SHALL compute pcen = pcwrite | (branch & zero) | (branchn & ~zero), combinationally within the same cycle.
REQ-019 SHALL decode alucontrol combinationally from the internal aluop:
- aluop 00 -> 010.
- aluop 01 -> 110.
- aluop 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.
- aluop 11 -> 010.
REQ-020 SHALL sample opcode only in DECODE and MEMADR; opcode changes in other states SHALL have no effect.
REQ-021 SHALL give the following instruction latencies: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.

Reset
REQ-022 SHALL, while reset=0, force the state to FETCH asynchronously, independent of clk.
REQ-023 SHALL, during reset, drive the FETCH outputs (irwrite=1, pcwrite=1, alusrcb=01, alucontrol=010, state_dbg=0); the datapath's own reset blocks the resulting writes.
REQ-024 SHALL abort any in-progress instruction on reset assertion mid-instruction; the first edge after release moves FETCH->DECODE.

Configuration
REQ-025 SHALL support the macro MULTICYCLE_BNE_EN. When defined, DECODE maps opcode 000101 (bne) to BRANCH, and BRANCH drives branchn=1 and branch=0 for bne, so pcen=~zero.
REQ-026 SHALL, when MULTICYCLE_BNE_EN is undefined, treat opcode 000101 as an unlisted opcode (DECODE->FETCH), and branchn SHALL be constant 0.

Verification
REQ-027 SHALL cover this reset scenario: hold reset=0 with opcode=100011 for 3 edges -> state_dbg=0 throughout; after release, state_dbg sequence is 1,2,3,4,0.
REQ-028 SHALL cover this lw/sw scenario: lw -> regwrite=1 and memtoreg=1 only in state 4; sw 101011 -> memwrite=1 and iord=1 only in state 5, then state 0.
REQ-029 SHALL cover this R-type scenario: opcode 000000, funct 100010 -> in state 6, alucontrol=110 and alusrca=1; in state 7, regdst=1 and regwrite=1. A funct of 000111 -> alucontrol=010.
REQ-030 SHALL cover this branch scenario: beq with zero=1 in state 8 -> pcen=1 and pcsrc=01; with zero=0 -> pcen=0. Run bne both with and without MULTICYCLE_BNE_EN; without the macro, bne goes 1->0 and pcen=0 in state 1.
REQ-031 SHALL cover this jump/no-op scenario: j 000010 -> state 11 with pcsrc=10 and pcen=1; illegal opcode 111111 -> 0,1,0 with no write strobe.
REQ-032 SHALL cover this mid-instruction reset scenario: assert reset=0 mid-addi, in state 9, between clock edges -> state_dbg=0 immediately and regwrite never asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore FSM controller for a multicycle MIPS-style datapath. Sequences
//   fetch/decode/execute/memory/writeback phases and decodes the ALU
//   operation from the instruction fields.
//
//   Optional feature: define MULTICYCLE_BNE_EN to add bne (opcode 000101),
//   which shares the BRANCH state but takes the branch when zero=0.
//
// Parameters
//   ALUCTRL_W : ALU control width (>=3); upper bits are zero-filled
//   STATE_W   : debug state port width (>=4); state is zero-extended
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset (0 = reset)
//   opcode     : instruction [31:26]
//   funct      : instruction [5:0]
//   zero       : ALU zero flag
//   pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst
//              : datapath enables / selects
//   alusrcb, pcsrc : 2-bit mux selects
//   alucontrol : ALU operation
//   state_dbg  : current FSM state encoding
module multicycle_controller #(
  parameter int ALUCTRL_W = 3,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  output logic                 pcen,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic                 iord,
  output logic                 memtoreg,
  output logic                 regdst,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic [STATE_W-1:0]   state_dbg
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t     state_reg, state_next;
  logic       pcwrite, branch, branchn;
  logic [1:0] aluop;
  logic [2:0] aluctl;
  logic       is_bne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= FETCH;
    else        state_reg <= state_next;
  end

`ifdef MULTICYCLE_BNE_EN
  // BRANCH is shared by beq and bne; remember which one was decoded so the
  // opcode bus does not need to stay stable into the BRANCH cycle.
  logic bne_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  bne_reg <= 1'b0;
    else if (state_reg == DECODE) bne_reg <= (opcode == OP_BNE);
  end
  assign is_bne = bne_reg;
`else
  assign is_bne = 1'b0;
`endif

  always_comb begin
    state_next = FETCH;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    branch     = 1'b0;
    branchn    = 1'b0;
    case (state_reg)
      FETCH: begin
        irwrite    = 1'b1;
        pcwrite    = 1'b1;
        alusrcb    = 2'b01;
        state_next = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
`ifdef MULTICYCLE_BNE_EN
          OP_BNE:       state_next = BRANCH;
`endif
          default:      state_next = FETCH;  // unknown opcode: no-op
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        // Opcode is re-sampled here; if it is neither lw nor sw the
        // instruction is abandoned rather than guessing a memory direction.
        if (opcode == OP_LW)      state_next = MEMRD;
        else if (opcode == OP_SW) state_next = MEMWR;
        else                      state_next = FETCH;
      end
      MEMRD: begin
        iord       = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        state_next = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = ~is_bne;
        branchn = is_bne;
      end
      ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_next = FETCH;  // unused encodings recover to FETCH
    endcase
  end

  always_comb begin
    aluctl = 3'b010;
    case (aluop)
      2'b01: aluctl = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: aluctl = 3'b010;
          6'b100010: aluctl = 3'b110;
          6'b100100: aluctl = 3'b000;
          6'b100101: aluctl = 3'b001;
          6'b101010: aluctl = 3'b111;
          default:   aluctl = 3'b010;
        endcase
      end
      default: aluctl = 3'b010;
    endcase
  end

  assign pcen       = pcwrite | (branch & zero) | (branchn & ~zero);
  assign alucontrol = ALUCTRL_W'(aluctl);
  assign state_dbg  = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes the
// hand-computed expected state and output vector for every cycle it drives;
// a monitor on the falling edge pops and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_controller #(.ALUCTRL_W(3), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .state_dbg(state_dbg)
  );

  // Observed vector: {pcen,memwrite,irwrite,regwrite,alusrca,iord,memtoreg,regdst,
  //                   alusrcb,pcsrc,alucontrol}
  logic [14:0] obs;
  assign obs = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                alusrcb, pcsrc, alucontrol};

  localparam logic [14:0] V_F    = {8'b1010_0000, 2'b01, 2'b00, 3'b010};
  localparam logic [14:0] V_D    = {8'b0000_0000, 2'b11, 2'b00, 3'b010};
  localparam logic [14:0] V_MA   = {8'b0000_1000, 2'b10, 2'b00, 3'b010};
  localparam logic [14:0] V_MR   = {8'b0000_0100, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] V_MWB  = {8'b0001_0010, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] V_MWR  = {8'b0100_0100, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] V_AWB  = {8'b0001_0001, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] V_AIWB = {8'b0001_0000, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] V_J    = {8'b1000_0000, 2'b00, 2'b10, 3'b010};
  // EXECUTE with a given ALU control; BRANCH with a given pcen
  localparam logic [14:0] V_EX_ADD = {8'b0000_1000, 2'b00, 2'b00, 3'b010};
  localparam logic [14:0] V_EX_SUB = {8'b0000_1000, 2'b00, 2'b00, 3'b110};
  localparam logic [14:0] V_EX_AND = {8'b0000_1000, 2'b00, 2'b00, 3'b000};
  localparam logic [14:0] V_EX_OR  = {8'b0000_1000, 2'b00, 2'b00, 3'b001};
  localparam logic [14:0] V_EX_SLT = {8'b0000_1000, 2'b00, 2'b00, 3'b111};
  localparam logic [14:0] V_BR_T   = {8'b1000_1000, 2'b00, 2'b01, 3'b110};
  localparam logic [14:0] V_BR_N   = {8'b0000_1000, 2'b00, 2'b01, 3'b110};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
  localparam logic [5:0] BNE = 6'b000101, XX = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] outs;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  // Drive one cycle's inputs shortly after the rising edge and queue the
  // expectation for the state the DUT sits in during that cycle.
  task automatic cyc(input string nm, input logic rst_v, input logic [5:0] op,
                     input logic [5:0] fn, input logic z,
                     input logic [3:0] st, input logic [14:0] v);
    exp_t e;
    @(posedge clk);
    #2;
    reset  = rst_v;
    opcode = op;
    funct  = fn;
    zero   = z;
    e.st   = st;
    e.outs = v;
    sb_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (state_dbg !== e.st || obs !== e.outs) begin
        n_fail++;
        $display("FAIL %s: state got %0d want %0d, outputs got %h want %h",
                 nm, state_dbg, e.st, obs, e.outs);
      end else begin
        $display("check %s: state %0d outputs %h", nm, state_dbg, obs);
      end
    end
  end

  initial begin
    // Reset held for three edges with lw on the bus, then lw runs 1,2,3,4,0
    cyc("rst0", 1'b0, LW, 6'd0, 1'b0, 4'd0, V_F);
    cyc("rst1", 1'b0, LW, 6'd0, 1'b0, 4'd0, V_F);
    cyc("rst2", 1'b0, LW, 6'd0, 1'b0, 4'd0, V_F);
    cyc("rst_rel", 1'b1, LW, 6'd0, 1'b0, 4'd0, V_F);
    cyc("lw_dec", 1'b1, LW, 6'd0, 1'b0, 4'd1, V_D);
    cyc("lw_adr", 1'b1, LW, 6'd0, 1'b0, 4'd2, V_MA);
    cyc("lw_rd", 1'b1, XX, 6'd0, 1'b0, 4'd3, V_MR);
    cyc("lw_wb", 1'b1, XX, 6'd0, 1'b0, 4'd4, V_MWB);
    // sw
    cyc("sw_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("sw_dec", 1'b1, SW, 6'd0, 1'b0, 4'd1, V_D);
    cyc("sw_adr", 1'b1, SW, 6'd0, 1'b0, 4'd2, V_MA);
    cyc("sw_wr", 1'b1, XX, 6'd0, 1'b0, 4'd5, V_MWR);
    // R-type: sub, unknown funct, and, or, slt
    cyc("sub_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("sub_dec", 1'b1, RT, 6'b100010, 1'b0, 4'd1, V_D);
    cyc("sub_ex", 1'b1, XX, 6'b100010, 1'b0, 4'd6, V_EX_SUB);
    cyc("sub_wb", 1'b1, XX, 6'b100010, 1'b0, 4'd7, V_AWB);
    cyc("f07_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("f07_dec", 1'b1, RT, 6'b000111, 1'b0, 4'd1, V_D);
    cyc("f07_ex", 1'b1, XX, 6'b000111, 1'b0, 4'd6, V_EX_ADD);
    cyc("f07_wb", 1'b1, XX, 6'b000111, 1'b0, 4'd7, V_AWB);
    cyc("and_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("and_dec", 1'b1, RT, 6'b100100, 1'b0, 4'd1, V_D);
    cyc("and_ex", 1'b1, XX, 6'b100100, 1'b0, 4'd6, V_EX_AND);
    cyc("or_ex_wb", 1'b1, XX, 6'b100101, 1'b0, 4'd7, V_AWB);
    cyc("or_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("or_dec", 1'b1, RT, 6'b100101, 1'b0, 4'd1, V_D);
    cyc("or_ex", 1'b1, XX, 6'b100101, 1'b0, 4'd6, V_EX_OR);
    cyc("or_wb", 1'b1, XX, 6'd0, 1'b0, 4'd7, V_AWB);
    cyc("slt_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("slt_dec", 1'b1, RT, 6'b101010, 1'b0, 4'd1, V_D);
    cyc("slt_ex", 1'b1, XX, 6'b101010, 1'b0, 4'd6, V_EX_SLT);
    cyc("slt_wb", 1'b1, XX, 6'd0, 1'b0, 4'd7, V_AWB);
    // beq taken / not taken; zero=1 in DECODE must not enable the PC
    cyc("beq1_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("beq1_dec", 1'b1, BEQ, 6'd0, 1'b1, 4'd1, V_D);
    cyc("beq1_br", 1'b1, XX, 6'd0, 1'b1, 4'd8, V_BR_T);
    cyc("beq0_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("beq0_dec", 1'b1, BEQ, 6'd0, 1'b0, 4'd1, V_D);
    cyc("beq0_br", 1'b1, XX, 6'd0, 1'b0, 4'd8, V_BR_N);
    // addi
    cyc("addi_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("addi_dec", 1'b1, ADDI, 6'd0, 1'b0, 4'd1, V_D);
    cyc("addi_ex", 1'b1, XX, 6'd0, 1'b0, 4'd9, V_MA);
    cyc("addi_wb", 1'b1, XX, 6'd0, 1'b0, 4'd10, V_AIWB);
    // j
    cyc("j_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("j_dec", 1'b1, JMP, 6'd0, 1'b0, 4'd1, V_D);
    cyc("j_jmp", 1'b1, XX, 6'd0, 1'b0, 4'd11, V_J);
    // illegal opcode: 0,1,0 with no strobe
    cyc("ill_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("ill_dec", 1'b1, XX, 6'd0, 1'b1, 4'd1, V_D);
`ifdef MULTICYCLE_BNE_EN
    cyc("bne0_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("bne0_dec", 1'b1, BNE, 6'd0, 1'b1, 4'd1, V_D);
    cyc("bne0_br", 1'b1, XX, 6'd0, 1'b0, 4'd8, V_BR_T);
    cyc("bne1_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("bne1_dec", 1'b1, BNE, 6'd0, 1'b0, 4'd1, V_D);
    cyc("bne1_br", 1'b1, XX, 6'd0, 1'b1, 4'd8, V_BR_N);
`else
    cyc("bne_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("bne_dec", 1'b1, BNE, 6'd0, 1'b0, 4'd1, V_D);
`endif
    // addi aborted by reset asserted mid-cycle in ADDIEXEC
    cyc("mr_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("mr_dec", 1'b1, ADDI, 6'd0, 1'b0, 4'd1, V_D);
    cyc("mr_ex", 1'b1, ADDI, 6'd0, 1'b0, 4'd9, V_MA);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (state_dbg !== 4'd0 || regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: state got %0d want 0, regwrite got %b want 0",
               state_dbg, regwrite);
    end else begin
      $display("check async_reset: state %0d regwrite %b", state_dbg, regwrite);
    end
    cyc("mr_hold", 1'b0, ADDI, 6'd0, 1'b0, 4'd0, V_F);
    cyc("mr_rel", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);
    cyc("mr2_dec", 1'b1, ADDI, 6'd0, 1'b0, 4'd1, V_D);
    cyc("mr2_ex", 1'b1, XX, 6'd0, 1'b0, 4'd9, V_MA);
    cyc("mr2_wb", 1'b1, XX, 6'd0, 1'b0, 4'd10, V_AIWB);
    cyc("end_f", 1'b1, XX, 6'd0, 1'b0, 4'd0, V_F);

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending got %0d want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
